// File: rtl/uart_tx_scheduler_if.sv
// Requester-side handshake bundle for uart_tx_scheduler.
// Each requester i owns bit i of req_valid/req_ready and byte i of req_data.
interface uart_tx_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;

    // Client side: presents bytes, observes the accept pulse.
    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    // Scheduler side: arbitrates and accepts bytes.
    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART TX line among N_REQ requesters.
// Bits advance on baud_tick pulses from an external generator whose divisor
// this block owns; divisor changes are only applied between frames.
module uart_tx_scheduler #(
    parameter int          N_REQ       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    localparam int         ID_W        = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_tx_scheduler_if.slave  req,
    input  logic                cfg_wr,
    input  logic [15:0]         cfg_div,
    input  logic                baud_tick,
    output logic [15:0]         baud_div,
    output logic                tx,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      shift_reg;
    // 0..7 select data bits; 8 means the stop bit is being driven next.
    logic [3:0]      bit_idx;
    logic            pend_valid;
    logic [15:0]     pend_div;
    logic [15:0]     cfg_eff;

    logic            grant_valid;
    logic [ID_W-1:0] grant_idx;
    logic            grant_fire;
    logic [N_REQ-1:0] ready_c;
    logic            frame_done_c;

    // A divisor of zero would stall the generator, so it is clamped to 1.
    assign cfg_eff = (cfg_div == 16'd0) ? 16'd1 : cfg_div;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!grant_valid && req.req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Next-state logic plus the combinational accept and frame-end pulses.
    always_comb begin
        state_next   = state;
        ready_c      = '0;
        frame_done_c = 1'b0;
        grant_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                // A pending divisor is applied first; arbitration waits one
                // cycle so the new divisor is visible before the next accept.
                if (!pend_valid && grant_valid) begin
                    grant_fire          = 1'b1;
                    ready_c[grant_idx]  = 1'b1;
                    state_next          = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (baud_tick) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick && bit_idx == 4'd8) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    frame_done_c = 1'b1;
                    state_next   = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Nothing is accepted or completed while reset is held.
        if (!reset_n) begin
            ready_c      = '0;
            frame_done_c = 1'b0;
            grant_fire   = 1'b0;
        end
    end

    assign req.req_ready = ready_c;
    assign frame_done    = frame_done_c;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: grant capture, serialisation, and divisor ownership.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            grant_id   <= '0;
            rr_ptr     <= '0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            baud_div   <= DEFAULT_DIV;
            pend_valid <= 1'b0;
            pend_div   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    // A fresh write supersedes anything still pending.
                    if (cfg_wr) begin
                        baud_div   <= cfg_eff;
                        pend_valid <= 1'b0;
                    end else if (pend_valid) begin
                        baud_div   <= pend_div;
                        pend_valid <= 1'b0;
                    end
                    if (grant_fire) begin
                        shift_reg <= req.req_data[8*grant_idx +: 8];
                        grant_id  <= grant_idx;
                        rr_ptr    <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                        busy      <= 1'b1;
                    end
                end
                S_WAIT_START: begin
                    if (baud_tick) begin
                        tx      <= 1'b0;
                        bit_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        tx      <= (bit_idx == 4'd8) ? 1'b1 : shift_reg[bit_idx[2:0]];
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        busy <= 1'b0;
                    end
                end
                default: begin
                    tx <= 1'b1;
                end
            endcase
            // Mid-frame writes are parked; last write wins.
            if (state != S_IDLE && cfg_wr) begin
                pend_div   <= cfg_eff;
                pend_valid <= 1'b1;
            end
        end
    end

endmodule
